eth_rx_fcs_check: RTL and testbench
===================================

ETH_RX_FCS_CHECK -- requirements
Module: eth_rx_fcs_check

Interface
REQ-001 SHALL have parameter MIN_LEN, default 64, minimum good frame length in bytes after SFD (FCS included).
REQ-002 SHALL have parameter MAX_LEN, default 1518, maximum good frame length in bytes after SFD (FCS included).
REQ-003 SHALL have port clock  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx_dv  input  1  GMII receive data valid.
REQ-006 SHALL have port rx_er  input  1  GMII receive error.
REQ-007 SHALL have port rx_data  input  8  GMII receive byte, first serial bit is bit 0.
REQ-008 SHALL have port out_valid  output  1  payload byte strobe (no backpressure).
REQ-009 SHALL have port out_data  output  8  payload byte (destination MAC through last data byte, FCS stripped).
REQ-010 SHALL have port out_last  output  1  marks last payload byte of a frame.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse, frame verdict valid.
REQ-012 SHALL have port frame_ok  output  1  verdict qualified by frame_done; 1 = good.
REQ-013 SHALL have port err_flags  output  4  verdict detail: {oversize, runt, rx_er seen, CRC mismatch}, qualified by frame_done.

Function
REQ-014 SHALL implement FSM states IDLE, PREAMBLE, DATA, DROP.
REQ-015 IDLE -> PREAMBLE when rx_dv=1 and rx_data=0x55; rx_dv=1 with any other byte -> DROP.
REQ-016 PREAMBLE: 0x55 stays; 0xD5 -> DATA (CRC := 0xFFFFFFFF, length := 0, buffer emptied); any other byte -> DROP; rx_dv=0 -> IDLE, no verdict.
REQ-017 DATA: each rx_dv=1 cycle updates CRC with rx_data (polynomial 0x04C11DB7, bit 0 first) and increments 11-bit saturating length.
REQ-018 DATA SHALL hold bytes in a 5-entry delay buffer; when a 6th byte arrives, oldest byte is emitted with out_valid=1, out_last=0 (latency 5 byte-cycles).
REQ-019 DATA rx_dv 1->0: if buffer holds 5 bytes, emit oldest with out_valid=1, out_last=1; same cycle pulse frame_done; remaining 4 bytes (FCS) discarded; -> IDLE.
REQ-020 Frame shorter than 5 bytes: no payload emitted, frame_done pulses with runt set, frame_ok=0.
REQ-021 CRC good iff post-FCS CRC register equals residue 0xC704DD7B.
REQ-022 frame_ok=1 iff CRC good, length in [MIN_LEN, MAX_LEN], and rx_er never asserted during DATA.
REQ-023 Length exceeding MAX_LEN: stop emitting payload immediately, without out_last; -> DROP; frame_done pulses with oversize set, frame_ok=0, when rx_dv falls.
REQ-024 rx_er=1 during DATA: latch error bit, continue forwarding; verdict reported at frame end.
REQ-025 DROP: ignore input until rx_dv=0, then -> IDLE; no output except REQ-023 verdict.
REQ-026 Back-to-back frames with a single rx_dv=0 cycle between them SHALL both be processed correctly.
REQ-027 out_data, err_flags SHALL be registered; outputs change only on rising clock.

Reset
REQ-028 Reset SHALL force IDLE, CRC 0xFFFFFFFF, length 0, buffer empty, out_valid/out_last/frame_done/frame_ok 0, out_data 0x00, err_flags 0.
REQ-029 Reset mid-frame SHALL abort without verdict; following rx_dv=1 cycles treated per REQ-015 (a frame in progress lands in DROP).

Structure
REQ-030 Shared package eth_pkg SHALL hold the FSM state enum, CRC_INIT 0xFFFFFFFF, CRC_RESIDUE 0xC704DD7B, PREAMBLE_BYTE 0x55, SFD_BYTE 0xD5, and error-bit index constants.
REQ-031 Combinational 8-bit CRC update SHALL be a sub-module crc32_d8_comb (data[7:0], crc_in[31:0] -> crc_out[31:0]), zero latency.

Verification
REQ-032 7x0x55, 0xD5, 60 bytes 0x00..0x3B, correct FCS -> 60 out_valid, bytes 0x00..0x3B, out_last on 0x3B, frame_done with frame_ok=1, err_flags=0.
REQ-033 Same frame, bit 0 of payload byte 10 flipped -> 60 bytes forwarded, frame_ok=0, err_flags=0001.
REQ-034 Valid 40-byte frame (36 payload + FCS) -> 36 bytes forwarded, frame_ok=0, err_flags=0100.
REQ-035 1600-byte frame -> exactly 1513 bytes emitted, no out_last, frame_done on rx_dv fall with err_flags bit 3 set.
REQ-036 rx_er pulsed at byte 20 of REQ-032 frame -> all 60 bytes forwarded, frame_ok=0, err_flags=0010.
REQ-037 reset asserted at byte 30 of REQ-032 frame, released, rx_dv held -> no further output; next clean frame after gap passes with frame_ok=1.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet receive FCS checker: FSM states,
// CRC-32 constants and the bit positions of the verdict error flags.
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } eth_state_e;

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
    localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    // err_flags bit positions: {oversize, runt, rx_er seen, CRC mismatch}
    localparam int ERR_CRC      = 0;
    localparam int ERR_RXER     = 1;
    localparam int ERR_RUNT     = 2;
    localparam int ERR_OVERSIZE = 3;

    // Holds back the trailing FCS so it never reaches the payload output
    localparam int BUF_DEPTH = 5;

endpackage

// File: rtl/crc32_d8_comb.sv
// One-byte combinational CRC-32 step, register kept un-reflected and the
// byte consumed bit 0 first, matching serial Ethernet order.
module crc32_d8_comb
    import eth_pkg::*;
(
    input  logic [7:0]  data,
    input  logic [31:0] crc_in,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[31] ^ data[i]) begin
                c = {c[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_rx_fcs_check.sv
// GMII receive path: strips preamble/SFD, forwards payload with the FCS
// removed, and reports a per-frame verdict (CRC, length, rx_er).
module eth_rx_fcs_check
    import eth_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_dv,
    input  logic       rx_er,
    input  logic [7:0] rx_data,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       frame_done,
    output logic       frame_ok,
    output logic [3:0] err_flags,
    output eth_state_e debug_state
);

    localparam logic [10:0] MIN_W = 11'(MIN_LEN);
    localparam logic [10:0] MAX_W = 11'(MAX_LEN);
    localparam logic [10:0] BUF_W = 11'(BUF_DEPTH);
    localparam logic [2:0]  FULL  = 3'(BUF_DEPTH);

    eth_state_e  state_q, state_d;
    logic [31:0] crc_q, crc_next;
    logic [10:0] len_q, len_inc;
    logic [2:0]  cnt_q;
    logic [7:0]  buf_q [BUF_DEPTH];
    logic        er_q, oversize_q;
    logic        over_next;

    logic        emit_d, emit_last_d, done_d, ok_d;
    logic [3:0]  flags_d;

    crc32_d8_comb u_crc (
        .data    (rx_data),
        .crc_in  (crc_q),
        .crc_out (crc_next)
    );

    assign len_inc     = (len_q == 11'h7FF) ? len_q : len_q + 11'd1;
    assign over_next   = (len_inc > MAX_W);
    assign debug_state = state_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rx_dv) begin
                    state_d = (rx_data == PREAMBLE_BYTE) ? PREAMBLE : DROP;
                end
            end
            PREAMBLE: begin
                if (!rx_dv) begin
                    state_d = IDLE;
                end else if (rx_data == SFD_BYTE) begin
                    state_d = DATA;
                end else if (rx_data != PREAMBLE_BYTE) begin
                    state_d = DROP;
                end
            end
            DATA: begin
                if (!rx_dv) begin
                    state_d = IDLE;
                end else if (over_next) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (!rx_dv) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // out_valid is a pure strobe: there is no ready, every flagged byte is taken.
    always_comb begin
        emit_d      = 1'b0;
        emit_last_d = 1'b0;
        done_d      = 1'b0;
        ok_d        = 1'b0;
        flags_d     = 4'b0000;
        case (state_q)
            DATA: begin
                if (rx_dv) begin
                    emit_d = (cnt_q == FULL) && !over_next;
                end else begin
                    emit_d                = (cnt_q == FULL);
                    emit_last_d           = (cnt_q == FULL);
                    done_d                = 1'b1;
                    flags_d[ERR_CRC]      = (crc_q != CRC_RESIDUE);
                    flags_d[ERR_RXER]     = er_q;
                    flags_d[ERR_RUNT]     = (len_q < MIN_W) || (len_q < BUF_W);
                    flags_d[ERR_OVERSIZE] = 1'b0;
                    ok_d                  = (flags_d == 4'b0000);
                end
            end
            DROP: begin
                if (!rx_dv && oversize_q) begin
                    done_d                = 1'b1;
                    flags_d[ERR_OVERSIZE] = 1'b1;
                    flags_d[ERR_RXER]     = er_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            crc_q      <= CRC_INIT;
            len_q      <= '0;
            cnt_q      <= '0;
            er_q       <= 1'b0;
            oversize_q <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= 8'h00;
            end
            out_valid  <= 1'b0;
            out_data   <= 8'h00;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            err_flags  <= 4'b0000;
        end else begin
            out_valid  <= emit_d;
            out_last   <= emit_last_d;
            frame_done <= done_d;
            frame_ok   <= ok_d;
            if (emit_d) begin
                out_data <= buf_q[0];
            end
            if (done_d) begin
                err_flags <= flags_d;
            end

            case (state_q)
                PREAMBLE: begin
                    if (rx_dv && rx_data == SFD_BYTE) begin
                        crc_q      <= CRC_INIT;
                        len_q      <= '0;
                        cnt_q      <= '0;
                        er_q       <= 1'b0;
                        oversize_q <= 1'b0;
                    end
                end
                DATA: begin
                    if (rx_dv) begin
                        crc_q <= crc_next;
                        len_q <= len_inc;
                        // Oldest byte sits in slot 0 once the buffer is full
                        for (int i = 0; i < BUF_DEPTH - 1; i++) begin
                            buf_q[i] <= buf_q[i+1];
                        end
                        buf_q[BUF_DEPTH-1] <= rx_data;
                        if (cnt_q != FULL) begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                        if (rx_er) begin
                            er_q <= 1'b1;
                        end
                        if (over_next) begin
                            oversize_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
                DROP: begin
                    if (!rx_dv) begin
                        oversize_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Directed bench for eth_rx_fcs_check: table of whole frames plus
// hand-written back-to-back, preamble-abort and mid-frame reset sequences.
module tb_eth_rx_fcs_check;
    import eth_pkg::*;

    logic       clock;
    logic       reset;
    logic       rx_dv;
    logic       rx_er;
    logic [7:0] rx_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       frame_done;
    logic       frame_ok;
    logic [3:0] err_flags;
    eth_state_e debug_state;

    eth_rx_fcs_check #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
        .clock       (clock),
        .reset       (reset),
        .rx_dv       (rx_dv),
        .rx_er       (rx_er),
        .rx_data     (rx_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .frame_done  (frame_done),
        .frame_ok    (frame_ok),
        .err_flags   (err_flags),
        .debug_state (debug_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         last_q[$];
    logic       ok_q[$];
    logic [3:0] flags_q[$];
    logic [7:0] tx_q[$];

    always @(negedge clock) begin
        if (out_valid) begin
            got_q.push_back(out_data);
            if (out_last) last_q.push_back(got_q.size() - 1);
        end
        if (frame_done) begin
            ok_q.push_back(frame_ok);
            flags_q.push_back(err_flags);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    // Reference FCS in the reflected form; transmitted least significant byte first.
    function automatic logic [31:0] fcs_of(input logic [7:0] b[$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (b[k]) begin
            c = c ^ {24'h0, b[k]};
            for (int j = 0; j < 8; j++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    // ---------------- drivers ----------------
    task automatic drive(input logic dv, input logic er, input logic [7:0] d);
        @(negedge clock);
        rx_dv   = dv;
        rx_er   = er;
        rx_data = d;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_frame(input int plen, input bit with_fcs, input int flip,
                              input int er_at, input int rst_at);
        logic [31:0] f;
        tx_q.delete();
        for (int k = 0; k < plen; k++) tx_q.push_back(8'(k));
        if (with_fcs) begin
            f = fcs_of(tx_q);
            for (int k = 0; k < 4; k++) tx_q.push_back(f[8*k +: 8]);
        end
        if (flip >= 0) tx_q[flip] = tx_q[flip] ^ 8'h01;
        for (int k = 0; k < 7; k++) drive(1'b1, 1'b0, PREAMBLE_BYTE);
        drive(1'b1, 1'b0, SFD_BYTE);
        for (int k = 0; k < tx_q.size(); k++) begin
            drive(1'b1, (k == er_at), tx_q[k]);
            if (k == rst_at) begin
                #2 reset = 1'b1;
            end else if (k == rst_at + 1) begin
                reset = 1'b0;
            end
        end
        drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic wait_verdicts(input int n, input int max_cycles);
        for (int k = 0; k < max_cycles && ok_q.size() < n; k++) @(negedge clock);
        repeat (3) @(negedge clock);
    endtask

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
        last_q.delete();
        ok_q.delete();
        flags_q.delete();
    endtask

    task automatic compare_bytes(input string name);
        int mism;
        mism = 0;
        check({name, "_count"}, got_q.size(), exp_q.size());
        foreach (got_q[k]) begin
            if (k < exp_q.size() && got_q[k] !== exp_q[k]) mism++;
        end
        check({name, "_bytes"}, mism, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int         plen;
        bit         with_fcs;
        int         flip;
        int         er_at;
        int         exp_n;
        bit         exp_last;
        bit         exp_ok;
        logic [3:0] exp_flags;
        logic [3:0] mask;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{60,   1, -1, -1, 60,   1, 1, 4'b0000, 4'b1111}; // good 64-byte frame
        vecs[1] = '{60,   1, 10, -1, 60,   1, 0, 4'b0001, 4'b1111}; // bit flip -> CRC
        vecs[2] = '{36,   1, -1, -1, 36,   1, 0, 4'b0100, 4'b1111}; // 40 bytes -> runt
        vecs[3] = '{1596, 1, -1, -1, 1513, 0, 0, 4'b1000, 4'b1000}; // 1600 bytes
        vecs[4] = '{60,   1, -1, 20, 60,   1, 0, 4'b0010, 4'b1111}; // rx_er at byte 20
        vecs[5] = '{3,    0, -1, -1, 0,    0, 0, 4'b0100, 4'b0100}; // 3 bytes, nothing out
        vecs[6] = '{59,   1, -1, -1, 59,   1, 0, 4'b0100, 4'b1111}; // 63 bytes
        vecs[7] = '{1514, 1, -1, -1, 1514, 1, 1, 4'b0000, 4'b1111}; // exactly 1518
        vecs[8] = '{1515, 1, -1, -1, 1513, 0, 0, 4'b1000, 4'b1000}; // 1519 bytes
        vecs[9] = '{1,    1, -1, -1, 1,    1, 0, 4'b0100, 4'b1111}; // exactly 5 bytes

        rx_dv   = 1'b0;
        rx_er   = 1'b0;
        rx_data = 8'h00;
        reset   = 1'b1;
        repeat (3) @(negedge clock);

        check("rst_out_valid",  out_valid,  1'b0);
        check("rst_out_data",   out_data,   8'h00);
        check("rst_out_last",   out_last,   1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_frame_ok",   frame_ok,   1'b0);
        check("rst_err_flags",  err_flags,  4'b0000);
        check("rst_state",      32'(debug_state), 32'(IDLE));
        reset = 1'b0;
        idle(2);

        for (int v = 0; v < 10; v++) begin
            clear_sb();
            for (int k = 0; k < vecs[v].exp_n; k++) begin
                exp_q.push_back((k == vecs[v].flip) ? (8'(k) ^ 8'h01) : 8'(k));
            end
            send_frame(vecs[v].plen, vecs[v].with_fcs, vecs[v].flip, vecs[v].er_at, -5);
            wait_verdicts(1, 20);
            check($sformatf("v%0d_verdicts", v), ok_q.size(), 1);
            if (ok_q.size() > 0) begin
                check($sformatf("v%0d_ok", v), ok_q[0], vecs[v].exp_ok);
                check($sformatf("v%0d_flags", v), flags_q[0] & vecs[v].mask, vecs[v].exp_flags);
            end
            compare_bytes($sformatf("v%0d", v));
            check($sformatf("v%0d_last_cnt", v), last_q.size(), vecs[v].exp_last ? 1 : 0);
            if (vecs[v].exp_last && last_q.size() > 0) begin
                check($sformatf("v%0d_last_pos", v), last_q[0], vecs[v].exp_n - 1);
            end
            idle(2);
        end

        // Back-to-back good frames separated by one idle cycle
        clear_sb();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 60; k++) exp_q.push_back(8'(k));
        end
        send_frame(60, 1, -1, -1, -5);
        send_frame(60, 1, -1, -1, -5);
        wait_verdicts(2, 20);
        check("b2b_verdicts", ok_q.size(), 2);
        if (ok_q.size() == 2) begin
            check("b2b_ok0", ok_q[0], 1'b1);
            check("b2b_ok1", ok_q[1], 1'b1);
        end
        compare_bytes("b2b");
        check("b2b_last_cnt", last_q.size(), 2);
        if (last_q.size() == 2) begin
            check("b2b_last0", last_q[0], 59);
            check("b2b_last1", last_q[1], 119);
        end
        idle(2);

        // Preamble cut short: no verdict, back in IDLE
        clear_sb();
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, PREAMBLE_BYTE);
        idle(10);
        check("abort_verdicts", ok_q.size(), 0);
        check("abort_bytes", got_q.size(), 0);
        check("abort_state", 32'(debug_state), 32'(IDLE));

        // Reset during byte 30: bytes 0..24 already out, nothing after, no verdict
        clear_sb();
        for (int k = 0; k < 25; k++) exp_q.push_back(8'(k));
        send_frame(60, 1, -1, -1, 30);
        wait_verdicts(1, 20);
        check("rst_mid_verdicts", ok_q.size(), 0);
        compare_bytes("rst_mid");
        check("rst_mid_last", last_q.size(), 0);

        clear_sb();
        idle(3);
        for (int k = 0; k < 60; k++) exp_q.push_back(8'(k));
        send_frame(60, 1, -1, -1, -5);
        wait_verdicts(1, 20);
        check("post_rst_verdicts", ok_q.size(), 1);
        if (ok_q.size() > 0) begin
            check("post_rst_ok", ok_q[0], 1'b1);
            check("post_rst_flags", flags_q[0], 4'b0000);
        end
        compare_bytes("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
